// File: rtl/utopia_rx_cell_assembler_if.sv
// Bundles the PHY byte link and the cell output port of the UTOPIA receive cell assembler.
// Handshakes: a PHY byte moves on a rising edge with en=1 and clav=1; a cell moves on a rising edge with valid=1 and ready=1.
interface utopia_rx_cell_assembler_if #(
  parameter int IfWidth    = 8,
  parameter int CELL_BYTES = 53,
  parameter int ERR_CNT_W  = 8
);
  logic [IfWidth-1:0]      data;
  logic                    soc;
  logic                    clav;
  logic                    en;
  logic [CELL_BYTES*8-1:0] ATMCell;
  logic                    valid;
  logic                    ready;
  logic                    soc_err;
  logic [ERR_CNT_W-1:0]    err_count;
  logic                    hec_err;
  logic [1:0]              state_dbg;

  modport master (
    input  data, soc, clav, ready,
    output en, ATMCell, valid, soc_err, err_count, hec_err, state_dbg
  );

  modport slave (
    output data, soc, clav, ready,
    input  en, ATMCell, valid, soc_err, err_count, hec_err, state_dbg
  );
endinterface

// File: rtl/utopia_rx_cell_assembler.sv
// UTOPIA Level-1 receive cell assembler: gathers 53-byte cells from a PHY and offers them on a valid/ready port.
// Defining UTOPIA_RX_HEC_CHECK_EN adds header HEC screening; cells with a bad HEC are dropped.
module utopia_rx_cell_assembler #(
  parameter int IfWidth    = 8,
  parameter int CELL_BYTES = 53,
  parameter int ERR_CNT_W  = 8
) (
  input logic                        clk_in,
  input logic                        reset,
  utopia_rx_cell_assembler_if.master bus
);
  localparam int CNT_W  = $clog2(CELL_BYTES);
  localparam int CELL_W = CELL_BYTES * 8;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CELL_BYTES - 1);

  typedef enum logic [1:0] {
    WAIT_SOC = 2'd0,
    RECEIVE  = 2'd1,
    HOLD     = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, wr_idx;
  logic                 en_q, valid_q, valid_d;
  logic                 soc_err_q, soc_err_d;
  logic                 store, xfer;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [CELL_W-1:0]    cell_q;

  generate
    if (IfWidth != 8) begin : g_bad_width
      $error("utopia_rx_cell_assembler: IfWidth must be 8");
    end
  endgenerate

  assign xfer = en_q & bus.clav;

`ifdef UTOPIA_RX_HEC_CHECK_EN
  localparam int HEC_LSB = (CELL_BYTES - 5) * 8;
  logic [7:0] crc_q;
  logic       hec_err_q, hec_err_d, hec_bad;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // The CRC rides along with header capture, so the verdict is ready on the first HOLD cycle.
  assign hec_bad = (crc_q ^ 8'h55) != cell_q[HEC_LSB +: 8];

  always_ff @(posedge clk_in) begin
    if (reset) begin
      crc_q     <= '0;
      hec_err_q <= 1'b0;
    end else begin
      hec_err_q <= hec_err_d;
      if (store && wr_idx < CNT_W'(4)) begin
        crc_q <= crc8_step((wr_idx == '0) ? 8'h00 : crc_q, bus.data);
      end
    end
  end

  assign bus.hec_err = hec_err_q;
`else
  assign bus.hec_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    soc_err_d = 1'b0;
    store     = 1'b0;
    wr_idx    = cnt_q;
`ifdef UTOPIA_RX_HEC_CHECK_EN
    hec_err_d = 1'b0;
`endif
    case (state_q)
      WAIT_SOC: begin
        if (xfer) begin
          if (bus.soc) begin
            store   = 1'b1;
            wr_idx  = '0;
            cnt_d   = CNT_W'(1);
            state_d = RECEIVE;
          end else begin
            soc_err_d = 1'b1;
          end
        end
      end
      RECEIVE: begin
        if (xfer) begin
          store = 1'b1;
          if (bus.soc) begin
            // Premature SOC: the partial cell is abandoned and this byte restarts framing.
            soc_err_d = 1'b1;
            wr_idx    = '0;
            cnt_d     = CNT_W'(1);
          end else if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (!valid_q) begin
`ifdef UTOPIA_RX_HEC_CHECK_EN
          if (hec_bad) begin
            hec_err_d = 1'b1;
            state_d   = WAIT_SOC;
          end else begin
            valid_d = 1'b1;
          end
`else
          valid_d = 1'b1;
`endif
        end else if (bus.ready) begin
          valid_d = 1'b0;
          state_d = WAIT_SOC;
        end
      end
      default: state_d = WAIT_SOC;
    endcase
    err_d = (soc_err_d && err_q != '1) ? err_q + ERR_CNT_W'(1) : err_q;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= WAIT_SOC;
      cnt_q     <= '0;
      en_q      <= 1'b0;
      valid_q   <= 1'b0;
      soc_err_q <= 1'b0;
      err_q     <= '0;
      cell_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      en_q      <= (state_d != HOLD);
      valid_q   <= valid_d;
      soc_err_q <= soc_err_d;
      err_q     <= err_d;
      for (int i = 0; i < CELL_BYTES; i++) begin
        if (store && wr_idx == CNT_W'(i)) begin
          cell_q[(CELL_BYTES-1-i)*8 +: 8] <= bus.data;
        end
      end
    end
  end

  assign bus.en        = en_q;
  assign bus.valid     = valid_q;
  assign bus.ATMCell   = cell_q;
  assign bus.soc_err   = soc_err_q;
  assign bus.err_count = err_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_utopia_rx_cell_assembler.sv
// Directed bench for utopia_rx_cell_assembler: a queue-based cell model checked every cycle plus hand-computed pins.
// Expectations follow UTOPIA_RX_HEC_CHECK_EN the same way the design does.
module tb_utopia_rx_cell_assembler;
  localparam int CB = 53;
  localparam int CW = CB * 8;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_in = ~clk_in;

  utopia_rx_cell_assembler_if bus ();
  utopia_rx_cell_assembler dut (.clk_in(clk_in), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference HEC: remainder of header*x^8 divided by x^8+x^2+x+1, then XOR 0x55.
  function automatic logic [7:0] hec_of(input logic [31:0] hdr);
    logic [39:0] r;
    r = {hdr, 8'h00};
    for (int i = 39; i >= 8; i--) begin
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    end
    return r[7:0] ^ 8'h55;
  endfunction

  function automatic logic [7:0] byte_at(input logic [CW-1:0] c, input int i);
    return c[(CB-1-i)*8 +: 8];
  endfunction

  function automatic logic [CW-1:0] make_cell(input logic [7:0] seed);
    logic [CW-1:0] c;
    for (int i = 0; i < CB; i++) c[(CB-1-i)*8 +: 8] = seed + 8'(i);
    c[(CB-5)*8 +: 8] = hec_of(c[CW-1 -: 32]);
    return c;
  endfunction

  // Model: bytes collected so far, a completed cell waiting one cycle, then presented until ready.
  logic [7:0]    partial[$];
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] m_cell;
  int            m_stage = 0;
  int            m_err_total = 0;
  bit            m_live = 0, m_en = 0, m_valid = 0, m_soc_err = 0, m_hec_err = 0;
  int            dut_deliv = 0;

  always @(posedge clk_in) begin
    if (reset) begin
      m_live = 1; partial.delete(); m_stage = 0; m_en = 0; m_valid = 0;
      m_soc_err = 0; m_hec_err = 0; m_err_total = 0;
    end else if (m_live) begin
      bit ok;
      m_soc_err = 0;
      m_hec_err = 0;
      if (m_stage == 2) begin
        if (bus.ready) begin m_valid = 0; m_stage = 0; m_en = 1; end
      end else if (m_stage == 1) begin
`ifdef UTOPIA_RX_HEC_CHECK_EN
        ok = (hec_of(m_cell[CW-1 -: 32]) == m_cell[CW-33 -: 8]);
`else
        ok = 1;
`endif
        if (ok) begin m_valid = 1; m_stage = 2; exp_q.push_back(m_cell); end
        else begin m_hec_err = 1; m_stage = 0; m_en = 1; end
      end else begin
        if (m_en && bus.clav) begin
          if (bus.soc) begin
            if (partial.size() != 0) begin m_soc_err = 1; m_err_total++; end
            partial.delete();
            partial.push_back(bus.data);
          end else if (partial.size() == 0) begin
            m_soc_err = 1; m_err_total++;
          end else begin
            partial.push_back(bus.data);
          end
          if (partial.size() == CB) begin
            for (int i = 0; i < CB; i++) m_cell[(CB-1-i)*8 +: 8] = partial[i];
            partial.delete();
            m_stage = 1;
          end
        end
        m_en = (m_stage == 0);
      end
    end
  end

  always @(negedge clk_in) begin
    if (m_live) begin
      check("en", CW'(bus.en), CW'(m_en));
      check("valid", CW'(bus.valid), CW'(m_valid));
      check("soc_err", CW'(bus.soc_err), CW'(m_soc_err));
      check("hec_err", CW'(bus.hec_err), CW'(m_hec_err));
      check("err_count", CW'(bus.err_count), CW'((m_err_total > 255) ? 255 : m_err_total));
      if (m_valid) check("cell_model", bus.ATMCell, m_cell);
    end
  end

  // Scoreboard: every accepted cell must match the oldest cell the model expected.
  always @(posedge clk_in) begin
    if (!reset && bus.valid && bus.ready) begin
      dut_deliv++;
      if (exp_q.size() == 0) check("unexpected_cell", CW'(1), CW'(0));
      else check("delivered_cell", bus.ATMCell, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit s);
    bus.data = d;
    bus.soc  = s;
    bus.clav = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (bus.en) begin
        tick();
        bus.clav = 1'b0;
        return;
      end
      tick();
    end
    bus.clav = 1'b0;
    check("send_timeout", CW'(0), CW'(1));
  endtask

  task automatic send_range(input logic [CW-1:0] c, input int first, input int last, input bit gap);
    for (int i = first; i <= last; i++) begin
      send_byte(byte_at(c, i), i == 0);
      if (gap) tick();
    end
  endtask

  task automatic wait_valid();
    for (int t = 0; t < 10; t++) begin
      if (bus.valid) return;
      tick();
    end
    check("valid_timeout", CW'(0), CW'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW-1:0] c0, c1, c2, c3, c4, h0, h1;
    logic [7:0]    b;
    bus.data = '0; bus.soc = 1'b0; bus.clav = 1'b0; bus.ready = 1'b0;
    check("hec_zero_hdr", CW'(hec_of(32'h0)), CW'(8'h55));
    check("hec_0123_hdr", CW'(hec_of(32'h00010203)), CW'(8'h1D));

    // Reset state
    repeat (2) tick();
    check("rst_en", CW'(bus.en), CW'(0));
    check("rst_valid", CW'(bus.valid), CW'(0));
    check("rst_cell", bus.ATMCell, CW'(0));
    check("rst_err_count", CW'(bus.err_count), CW'(0));
    reset = 1'b0;
    tick();

    // Clean cell 0x00..0x34 with ready high
    for (int i = 0; i < CB; i++) c0[(CB-1-i)*8 +: 8] = 8'(i);
    bus.ready = 1'b1;
    send_range(c0, 0, CB - 1, 0);
    check("last_byte_en", CW'(bus.en), CW'(0));
    check("last_byte_valid", CW'(bus.valid), CW'(0));
    tick();
`ifdef UTOPIA_RX_HEC_CHECK_EN
    check("c0_hec_err", CW'(bus.hec_err), CW'(1));
    check("c0_no_valid", CW'(bus.valid), CW'(0));
`else
    check("c0_valid", CW'(bus.valid), CW'(1));
    b = bus.ATMCell[CW-1 -: 8];
    check("c0_byte0", CW'(b), CW'(8'h00));
    b = bus.ATMCell[7:0];
    check("c0_byte52", CW'(b), CW'(8'h34));
    check("c0_hold_en", CW'(bus.en), CW'(0));
    tick();
    check("c0_valid_drop", CW'(bus.valid), CW'(0));
`endif
    tick();

    // Back-pressure: ready low for 10 cycles while the PHY keeps offering a byte
    c1 = make_cell(8'h40);
    bus.ready = 1'b0;
    send_range(c1, 0, CB - 1, 0);
    bus.data = 8'hAA; bus.soc = 1'b1; bus.clav = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", CW'(bus.valid), CW'(1));
      check("bp_cell", bus.ATMCell, c1);
      check("bp_en", CW'(bus.en), CW'(0));
      tick();
    end
    bus.clav = 1'b0; bus.soc = 1'b0;
    bus.ready = 1'b1;
    tick();
    check("bp_release_valid", CW'(bus.valid), CW'(0));
    check("bp_release_en", CW'(bus.en), CW'(1));

    // clav toggling every cycle
    c2 = make_cell(8'h80);
    send_range(c2, 0, CB - 1, 1);
    wait_valid();
    check("toggle_cell", bus.ATMCell, c2);
    tick();

    // Premature SOC at byte 20
    c3 = make_cell(8'hA0);
    c4 = make_cell(8'hC0);
    send_range(c3, 0, 19, 0);
    send_byte(byte_at(c4, 0), 1'b1);
    check("premature_soc_err", CW'(bus.soc_err), CW'(1));
    check("premature_err_count", CW'(bus.err_count), CW'(1));
    send_range(c4, 1, CB - 1, 0);
    wait_valid();
    check("premature_new_cell", bus.ATMCell, c4);
    tick();
    tick();

    // 300 bytes without SOC saturate the counter, then reset mid-cell
    for (int i = 0; i < 300; i++) send_byte(8'(i), 1'b0);
    check("sat_err_count", CW'(bus.err_count), CW'(255));
    send_range(c1, 0, 9, 0);
    reset = 1'b1;
    tick();
    check("midreset_err_count", CW'(bus.err_count), CW'(0));
    check("midreset_valid", CW'(bus.valid), CW'(0));
    check("midreset_en", CW'(bus.en), CW'(0));
    reset = 1'b0;
    tick();

    // HEC: all-zero header with 0x55 passes, with 0x54 fails when screening is built in
    for (int i = 0; i < CB; i++) h0[(CB-1-i)*8 +: 8] = (i < 4) ? 8'h00 : 8'(i);
    h0[(CB-5)*8 +: 8] = 8'h55;
    h1 = h0;
    h1[(CB-5)*8 +: 8] = 8'h54;
    send_range(h0, 0, CB - 1, 0);
    wait_valid();
    check("hec_good_cell", bus.ATMCell, h0);
    tick();
    send_range(h1, 0, CB - 1, 0);
    tick();
`ifdef UTOPIA_RX_HEC_CHECK_EN
    check("hec_bad_pulse", CW'(bus.hec_err), CW'(1));
    check("hec_bad_no_valid", CW'(bus.valid), CW'(0));
    repeat (3) tick();
    check("hec_bad_total", CW'(dut_deliv), CW'(4));
`else
    check("hec_off_valid", CW'(bus.valid), CW'(1));
    check("hec_off_cell", bus.ATMCell, h1);
    repeat (3) tick();
    check("hec_off_total", CW'(dut_deliv), CW'(6));
`endif
    check("scoreboard_empty", CW'(exp_q.size()), CW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
